// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller.
// Contents: default source count, bridge register offsets, CTRL bit positions,
// STATUS field position and the controller FSM state encoding.
package intc_pkg;

    localparam int N_IRQ_DEFAULT = 6;

    // Register word offsets as seen on the bridge slot
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_PEND   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_IE_BIT = 0;
    localparam int CTRL_RR_BIT = 1;

    // STATUS layout: state in bits 9:8, int_id in bits 2:0
    localparam int STATUS_STATE_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intc_prio_pick.sv
// Combinational winner selection for the interrupt controller.
// Ports:
//   eligible : pending-and-unmasked sources
//   rr_ptr   : round-robin start index (always < N_IRQ)
//   rr_mode  : 0 = lowest index wins, 1 = first index at or above rr_ptr, wrapping
//   valid    : at least one eligible source
//   id       : index of the winning source (0 when none)
module intc_prio_pick
    import intc_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT
) (
    input  logic [N_IRQ-1:0] eligible,
    input  logic [2:0]       rr_ptr,
    input  logic             rr_mode,
    output logic             valid,
    output logic [2:0]       id
);

    logic [2:0] base;
    logic [3:0] idx;

    // Walk offsets from the far end back to the start so the candidate
    // closest to the search base is the last one written and therefore wins.
    always_comb begin
        base  = rr_mode ? rr_ptr : 3'd0;
        valid = |eligible;
        id    = 3'd0;
        idx   = 4'd0;
        for (int off = N_IRQ - 1; off >= 0; off--) begin
            idx = {1'b0, base} + 4'(off);
            if (idx >= 4'(N_IRQ)) begin
                idx = idx - 4'(N_IRQ);
            end
            if (eligible[idx[2:0]]) begin
                id = idx[2:0];
            end
        end
    end

endmodule

// File: rtl/intc.sv
// Interrupt controller: edge-detects device lines into PEND, arbitrates among
// unmasked pending sources and runs a single-level request/service handshake
// with the CPU controller.
// Ports:
//   clk, reset (async, active low)
//   irq      : device level lines, a rising edge is an event
//   we/addr/wdata/rdata : bridge register slot (CTRL, MASK, PEND, STATUS)
//   int_req  : registered request to the CPU, high exactly in REQ
//   int_ack  : CPU took the interrupt; eret : CPU left the handler
//   int_id   : latched source ID
module intc
    import intc_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             int_req,
    input  logic             int_ack,
    input  logic             eret,
    output logic [2:0]       int_id
);

    state_t             state_reg;
    logic               int_req_reg;
    logic [2:0]         int_id_reg;
    logic [2:0]         rr_ptr_reg;
    logic               ie_reg;
    logic               rr_mode_reg;
    logic [N_IRQ-1:0]   mask_reg;
    logic [N_IRQ-1:0]   pend_reg;
    logic [N_IRQ-1:0]   irq_hist_reg;

    logic               ie_next;
    logic               rr_mode_next;
    logic [N_IRQ-1:0]   mask_next;
    logic [N_IRQ-1:0]   pend_next;
    logic [N_IRQ-1:0]   pend_set;
    logic [N_IRQ-1:0]   pend_clr;
    logic               pick_valid;
    logic [2:0]         pick_id;
    logic               unused_wdata;

    assign unused_wdata = ^wdata[31:N_IRQ];

    // Register file next values
    always_comb begin
        ie_next      = ie_reg;
        rr_mode_next = rr_mode_reg;
        mask_next    = mask_reg;
        pend_clr     = '0;
        if (we && addr == ADDR_CTRL) begin
            ie_next      = wdata[CTRL_IE_BIT];
            rr_mode_next = wdata[CTRL_RR_BIT];
        end
        if (we && addr == ADDR_MASK) begin
            mask_next = wdata[N_IRQ-1:0];
        end
        if (we && addr == ADDR_PEND) begin
            pend_clr = wdata[N_IRQ-1:0];
        end
        // An acknowledge only counts while a request is outstanding
        if (state_reg == ST_REQ && int_ack) begin
            pend_clr = pend_clr | (N_IRQ'(1) << int_id_reg);
        end
    end

    // A new edge overrides any clear of the same bit in the same cycle
    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
            assign pend_set[gi]  = irq[gi] & ~irq_hist_reg[gi];
            assign pend_next[gi] = pend_set[gi] | (pend_reg[gi] & ~pend_clr[gi]);
        end
    endgenerate

    intc_prio_pick #(
        .N_IRQ(N_IRQ)
    ) u_pick (
        .eligible (pend_reg & mask_reg),
        .rr_ptr   (rr_ptr_reg),
        .rr_mode  (rr_mode_reg),
        .valid    (pick_valid),
        .id       (pick_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_reg       <= 1'b0;
            rr_mode_reg  <= 1'b0;
            mask_reg     <= '0;
            pend_reg     <= '0;
            irq_hist_reg <= '0;
        end else begin
            ie_reg       <= ie_next;
            rr_mode_reg  <= rr_mode_next;
            mask_reg     <= mask_next;
            pend_reg     <= pend_next;
            irq_hist_reg <= irq;
        end
    end

    // Request/service FSM. The withdraw test in REQ looks at the values the
    // registers take on this edge, so a software clear drops int_req on the
    // very edge that applies it; an acknowledge in the same cycle still wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            int_req_reg <= 1'b0;
            int_id_reg  <= 3'd0;
            rr_ptr_reg  <= 3'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ie_reg && pick_valid) begin
                        state_reg   <= ST_REQ;
                        int_req_reg <= 1'b1;
                        int_id_reg  <= pick_id;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_reg   <= ST_SERVICE;
                        int_req_reg <= 1'b0;
                        rr_ptr_reg  <= (int_id_reg == 3'(N_IRQ - 1)) ? 3'd0 : int_id_reg + 3'd1;
                    end else if (!ie_next || !mask_next[int_id_reg] || !pend_next[int_id_reg]) begin
                        state_reg   <= ST_IDLE;
                        int_req_reg <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eret) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    int_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign int_req = int_req_reg;
    assign int_id  = int_id_reg;

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL: begin
                rdata[CTRL_IE_BIT] = ie_reg;
                rdata[CTRL_RR_BIT] = rr_mode_reg;
            end
            ADDR_MASK: rdata[N_IRQ-1:0] = mask_reg;
            ADDR_PEND: rdata[N_IRQ-1:0] = pend_reg;
            default: begin
                rdata[STATUS_STATE_LSB+1:STATUS_STATE_LSB] = state_reg;
                rdata[2:0] = int_id_reg;
            end
        endcase
    end

endmodule
